alu_entry_ctrl: RTL

//  Sequences operand/opcode entry for the 6-bit two's-complement ALU from board switches and keys.

---
 rtl/alu_entry_ctrl_if.sv | 32 +++
 rtl/alu_entry_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_entry_ctrl_if.sv
// Board/ALU-side signal bundle for the ALU entry controller.
// The controller takes the slave view: it receives switches, raw keys and
// the ALU's combinational result, and drives operands, opcode, the latched
// result and the display blanking controls.
interface alu_entry_ctrl_if;
    logic [5:0] sw;
    logic       key_enter_n;
    logic       key_clear_n;
    logic [5:0] alu_result;
    logic       alu_ovf;
    logic [5:0] a_out;
    logic [5:0] b_out;
    logic [2:0] op_out;
    logic [5:0] res_out;
    logic       ovf_out;
    logic       blank_a;
    logic       blank_b;
    logic       blank_r;
    logic [2:0] state_out;

    modport master (
        output sw, key_enter_n, key_clear_n, alu_result, alu_ovf,
        input  a_out, b_out, op_out, res_out, ovf_out,
        input  blank_a, blank_b, blank_r, state_out
    );

    modport slave (
        input  sw, key_enter_n, key_clear_n, alu_result, alu_ovf,
        output a_out, b_out, op_out, res_out, ovf_out,
        output blank_a, blank_b, blank_r, state_out
    );
endinterface

// File: rtl/alu_entry_ctrl.sv
// Operand/opcode entry sequencer for a 6-bit two's-complement ALU.
// Debounces the enter/clear keys, walks A -> B -> opcode -> execute -> show,
// lets the field being edited follow the switches live, latches the ALU
// result and produces per-field blink blanking for the display.
module alu_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic            clk,
    input  logic            reset_n,
    alu_entry_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_ENTER_OP = 3'd2,
        ST_EXEC     = 3'd3,
        ST_SHOW     = 3'd4
    } state_t;

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW = $clog2(BLINK_CYCLES);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    // Key index 0 is enter, index 1 is clear.
    localparam int K_ENTER = 0;
    localparam int K_CLEAR = 1;

    logic [1:0]          key_raw_s;
    logic [1:0]          key_meta_r;
    logic [1:0]          key_sync_r;
    logic [1:0]          key_deb_r;
    logic [1:0]          key_press_r;
    logic [1:0][DW-1:0]  deb_cnt_r;

    logic                enter_s;
    logic                clear_s;

    state_t              state_r;
    state_t              state_next_s;

    logic [5:0]          a_r;
    logic [5:0]          b_r;
    logic [2:0]          op_r;
    logic [5:0]          res_r;
    logic                ovf_r;

    logic [BW-1:0]       blink_cnt_r;
    logic [BW-1:0]       blink_cnt_next_s;
    logic                phase_r;
    logic                phase_next_s;

    logic                blank_a_r;
    logic                blank_b_r;
    logic                blank_r_r;

    assign key_raw_s = {bus.key_clear_n, bus.key_enter_n};

    // Two-flop synchronizer bringing the asynchronous keys into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_r <= 2'b11;
            key_sync_r <= 2'b11;
        end else begin
            key_meta_r <= key_raw_s;
            key_sync_r <= key_meta_r;
        end
    end

    // Debounce each key and emit a one-cycle pulse on an accepted press (1->0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_deb_r   <= 2'b11;
            key_press_r <= 2'b00;
            deb_cnt_r   <= {2{{DW{1'b0}}}};
        end else begin
            for (int i = 0; i < 2; i++) begin
                key_press_r[i] <= 1'b0;
                if (key_sync_r[i] == key_deb_r[i]) begin
                    deb_cnt_r[i] <= {DW{1'b0}};
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    // Stable long enough: accept the new level; only a
                    // falling edge counts as a press, release is silent.
                    deb_cnt_r[i]   <= {DW{1'b0}};
                    key_deb_r[i]   <= key_sync_r[i];
                    key_press_r[i] <= ~key_sync_r[i];
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + {{(DW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign enter_s = key_press_r[K_ENTER];
    assign clear_s = key_press_r[K_CLEAR];

    // Next-state logic; clear overrides enter, and EXEC ignores enter.
    always_comb begin
        state_next_s = state_r;
        if (clear_s) begin
            state_next_s = ST_ENTER_A;
        end else begin
            case (state_r)
                ST_ENTER_A: begin
                    if (enter_s) state_next_s = ST_ENTER_B;
                    else         state_next_s = ST_ENTER_A;
                end
                ST_ENTER_B: begin
                    if (enter_s) state_next_s = ST_ENTER_OP;
                    else         state_next_s = ST_ENTER_B;
                end
                ST_ENTER_OP: begin
                    if (enter_s) state_next_s = ST_EXEC;
                    else         state_next_s = ST_ENTER_OP;
                end
                ST_EXEC: begin
                    state_next_s = ST_SHOW;
                end
                ST_SHOW: begin
                    if (enter_s) state_next_s = ST_ENTER_A;
                    else         state_next_s = ST_SHOW;
                end
                default: begin
                    state_next_s = ST_ENTER_A;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_ENTER_A;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand/opcode capture on enter, result capture on leaving EXEC, clear wipes all.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r   <= 6'd0;
            b_r   <= 6'd0;
            op_r  <= 3'd0;
            res_r <= 6'd0;
            ovf_r <= 1'b0;
        end else if (clear_s) begin
            a_r   <= 6'd0;
            b_r   <= 6'd0;
            op_r  <= 3'd0;
            res_r <= 6'd0;
            ovf_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ENTER_A: begin
                    if (enter_s) a_r <= bus.sw;
                end
                ST_ENTER_B: begin
                    if (enter_s) b_r <= bus.sw;
                end
                ST_ENTER_OP: begin
                    if (enter_s) op_r <= bus.sw[2:0];
                end
                ST_EXEC: begin
                    // ALU settles within one cycle of the operands being held.
                    res_r <= bus.alu_result;
                    ovf_r <= bus.alu_ovf;
                end
                default: begin
                    a_r <= a_r;
                end
            endcase
        end
    end

    // Blink counter next value; restarts from phase 0 on any state change or clear.
    always_comb begin
        blink_cnt_next_s = blink_cnt_r;
        phase_next_s     = phase_r;
        if (clear_s || (state_next_s != state_r)) begin
            blink_cnt_next_s = {BW{1'b0}};
            phase_next_s     = 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_next_s = {BW{1'b0}};
            phase_next_s     = ~phase_r;
        end else begin
            blink_cnt_next_s = blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
            phase_next_s     = phase_r;
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_r <= {BW{1'b0}};
            phase_r     <= 1'b0;
        end else begin
            blink_cnt_r <= blink_cnt_next_s;
            phase_r     <= phase_next_s;
        end
    end

    // Registered blanking, computed from next state/phase so it lines up with state_r.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_a_r <= 1'b0;
            blank_b_r <= 1'b0;
            blank_r_r <= 1'b0;
        end else begin
            blank_a_r <= (state_next_s == ST_ENTER_A) && phase_next_s;
            blank_b_r <= (state_next_s == ST_ENTER_B) && phase_next_s;
            blank_r_r <= (state_next_s != ST_SHOW);
        end
    end

    // The field being edited follows the switches live; otherwise show the latch.
    assign bus.a_out     = (state_r == ST_ENTER_A)  ? bus.sw      : a_r;
    assign bus.b_out     = (state_r == ST_ENTER_B)  ? bus.sw      : b_r;
    assign bus.op_out    = (state_r == ST_ENTER_OP) ? bus.sw[2:0] : op_r;
    assign bus.res_out   = res_r;
    assign bus.ovf_out   = ovf_r;
    assign bus.blank_a   = blank_a_r;
    assign bus.blank_b   = blank_b_r;
    assign bus.blank_r   = blank_r_r;
    assign bus.state_out = state_r;

endmodule
